// File: rtl/act_lut_pkg.sv
// act_lut_pkg: shared constants and FSM state type for the
// programmable activation lookup table.
package act_lut_pkg;

    localparam int ACT_DATA_W    = 8;
    localparam int ACT_LUT_DEPTH = 256;
    localparam int ACT_CSUM_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } act_state_t;

endpackage

// File: rtl/act_lut_ram.sv
// act_lut_ram: DEPTH x DATA_W table storage, one sync write port and
// one sync read port with a registered output.
// Ports: clk, rst_n, we/waddr/wdata (write), re/raddr/rdata (read).
module act_lut_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage itself is never reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register holds its value between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/act_lut_prog.sv
// act_lut_prog: runtime-loadable activation LUT. A config stream loads
// 256 entries; afterwards lookups return table[in_data] one cycle later.
// Ports: clk, rst_n; cfg_start/cfg_valid/cfg_data/cfg_ready/cfg_done load
// path; table_ok, checksum status; in_valid/in_data/in_ready and
// out_valid/out_data lookup path.
// Optional: define ACT_LUT_CHECKSUM_EN to enable the load checksum;
// otherwise checksum reads as 0.
module act_lut_prog
    import act_lut_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int DEPTH  = ACT_LUT_DEPTH,
    parameter int CSUM_W = ACT_CSUM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              cfg_done,
    output logic              table_ok,
    output logic [CSUM_W-1:0] checksum,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int ADDR_W = $clog2(DEPTH);

    act_state_t        state;
    act_state_t        state_nx;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en;
    logic              last_wr;
    logic              rd_en;

    assign in_ready = (state == ACTIVE);

    // A restart pulse takes precedence over a coincident write.
    assign wr_en   = !cfg_start && cfg_valid && cfg_ready
                     && (state == LOAD);
    assign last_wr = wr_en && (wr_ptr == ADDR_W'(DEPTH - 1));
    assign rd_en   = in_valid && in_ready;

    always_comb begin
        state_nx = state;
        if (cfg_start) begin
            state_nx = LOAD;
        end else if (last_wr) begin
            state_nx = ACTIVE;
        end
    end

    // Status flags are decoded from the next state so they line up
    // with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            cfg_ready <= 1'b0;
            table_ok  <= 1'b0;
            cfg_done  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_ready <= (state_nx == LOAD);
            table_ok  <= (state_nx == ACTIVE);
            cfg_done  <= last_wr;
            out_valid <= rd_en;
            if (cfg_start) begin
                wr_ptr <= '0;
            end else if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

`ifdef ACT_LUT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (cfg_start) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + CSUM_W'(cfg_data);
        end
    end
`else
    assign checksum = '0;
`endif

    act_lut_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (cfg_data),
        .re    (rd_en),
        .raddr (in_data),
        .rdata (out_data)
    );

endmodule

// File: tb/tb_act_lut_prog.sv
// tb_act_lut_prog: scoreboard bench for act_lut_prog covering load,
// restart, reset-during-load and lookup paths.
module tb_act_lut_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic        cfg_valid;
    logic [7:0]  cfg_data;
    logic        cfg_ready;
    logic        cfg_done;
    logic        table_ok;
    logic [15:0] checksum;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] src [256];
    logic [7:0] mem [256];
    logic [7:0] lk  [8];
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    act_lut_prog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .table_ok  (table_ok),
        .checksum  (checksum),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [15:0] exp_csum(input int n);
        logic [15:0] s;
        s = '0;
`ifdef ACT_LUT_CHECKSUM_EN
        for (int i = 0; i < n; i++) s = s + {8'h00, src[i]};
`endif
        return s;
    endfunction

    // Scoreboard consumer: every valid output pops one expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_out_valid", 1, 0);
            end else begin
                check("lookup_data", {24'h0, out_data},
                      {24'h0, sb_q.pop_front()});
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_cfg_done"}, cfg_done, 0);
        check({tag, "_table_ok"}, table_ok, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_checksum"}, checksum, 0);
    endtask

    task automatic load_table(input bit gap, input int n,
                              input bit do_start, output int cyc);
        int i;
        int dones;
        if (do_start) begin
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            check("start_cfg_ready", cfg_ready, 1);
            check("start_checksum", checksum, 0);
            check("start_table_ok", table_ok, 0);
        end
        i = 0;
        cyc = 0;
        dones = 0;
        while (i < n) begin
            if (gap && cyc[0]) begin
                cfg_valid = 1'b0;
            end else begin
                cfg_valid = 1'b1;
                cfg_data  = src[i];
            end
            if (cfg_done) dones++;
            if (cfg_valid && cfg_ready) begin
                mem[i] = src[i];
                i++;
            end
            cyc++;
            tick();
            if (cyc > 4 * n + 16) begin
                check("load_budget", cyc, 4 * n + 16);
                break;
            end
        end
        cfg_valid = 1'b0;
        check("done_early", dones, 0);
        if (n == 256) begin
            check("done_pulse", cfg_done, 1);
            check("load_table_ok", table_ok, 1);
            check("load_cfg_ready", cfg_ready, 0);
            check("load_checksum", checksum, exp_csum(256));
            tick();
            check("done_clear", cfg_done, 0);
        end
    endtask

    task automatic lookup_burst(input int n);
        for (int j = 0; j <= n; j++) begin
            if (j > 0) check("out_valid_cont", out_valid, 1);
            if (j < n) begin
                in_valid = 1'b1;
                in_data  = lk[j];
                if (in_ready) sb_q.push_back(mem[lk[j]]);
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("idle_out_valid", out_valid, 0);
        check("hold_out_data", out_data, mem[lk[n-1]]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int x;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (2) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (3) begin
            tick();
            check("noload_in_ready", in_ready, 0);
            check("noload_out_valid", out_valid, 0);
            check("noload_table_ok", table_ok, 0);
            check("noload_checksum", checksum, 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        load_table(1'b0, 256, 1'b1, cyc);
        check("held_load_cycles", cyc, 256);
`ifdef ACT_LUT_CHECKSUM_EN
        check("identity_csum", checksum, 16'h7F80);
`endif

        lk[0] = 8'h80; lk[1] = 8'hFF; lk[2] = 8'h00; lk[3] = 8'h7F;
        lookup_burst(4);

        cfg_valid = 1'b1;
        cfg_data  = 8'h55;
        repeat (3) tick();
        cfg_valid = 1'b0;
        check("stray_cfg_csum", checksum, exp_csum(256));
        check("stray_cfg_ok", table_ok, 1);
        lk[0] = 8'h00;
        lookup_burst(1);

        load_table(1'b1, 256, 1'b1, cyc);
        check("gap_load_cycles", cyc, 511);

        in_valid  = 1'b1;
        in_data   = 8'hFD;
        sb_q.push_back(mem[8'hFD]);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        check("overlap_cfg_ready", cfg_ready, 1);
        check("overlap_table_ok", table_ok, 0);
        check("overlap_in_ready", in_ready, 0);

        for (int i = 0; i < 256; i++) src[i] = 8'(i) ^ 8'hA5;
        load_table(1'b0, 100, 1'b0, cyc);
        for (int i = 0; i < 256; i++) begin
            x = int'($signed(8'(i)));
            if (x >= 0) src[i] = 8'(x);
            else if (x < -32) src[i] = 8'h00;
            else src[i] = 8'(-((-x) >>> 3));
        end
        load_table(1'b0, 256, 1'b1, cyc);
        lk[0] = 8'h02; lk[1] = 8'hFF; lk[2] = 8'h80;
        lk[3] = 8'hE0; lk[4] = 8'h7F;
        lookup_burst(5);

        for (int i = 0; i < 256; i++) src[i] = 8'(i);
        load_table(1'b0, 50, 1'b1, cyc);
        rst_n = 1'b0;
        #1;
        check_reset("midload_rst");
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd5;
        repeat (2) begin
            tick();
            check("post_rst_in_ready", in_ready, 0);
            check("post_rst_out_valid", out_valid, 0);
            check("post_rst_table_ok", table_ok, 0);
        end
        in_valid = 1'b0;
        load_table(1'b0, 256, 1'b1, cyc);
        lk[0] = 8'h05; lk[1] = 8'hFF; lk[2] = 8'h02;
        lookup_burst(3);

        repeat (2) tick();
        check("scoreboard_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
